// File: rtl/modular_multiplier.sv
// Sequential modular multiplier: M = (A*B) mod p using MSB-first interleaved shift-add.
// One operand bit per clock, so a result is ready n+1 edges after the reset is released.
module modular_multiplier #(
    parameter int n = 300
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] p,
    output logic [n-1:0] M,
    output logic         flag
);

    localparam int CW = $clog2(n + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state_reg;
    logic [n-1:0]  a_reg;
    logic [n+1:0]  b_reg;
    logic [n+1:0]  p_reg;
    logic [n+1:0]  r_reg;
    logic [CW-1:0] cnt_reg;

    // stage[0] = 2R + a_i*B (< 3p); each following stage strips at most one p
    logic [n+1:0]  stage [0:2];

    assign stage[0] = (r_reg << 1) + (a_reg[n-1] ? b_reg : '0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_reduce
            assign stage[gi+1] = (stage[gi] >= p_reg) ? (stage[gi] - p_reg) : stage[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            M         <= '0;
            flag      <= 1'b0;
            r_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                // The first released edge performs the load and moves straight on to RUN
                IDLE, LOAD: begin
                    a_reg     <= A;
                    b_reg     <= {2'b00, B};
                    p_reg     <= {2'b00, p};
                    r_reg     <= '0;
                    cnt_reg   <= CW'(n);
                    state_reg <= RUN;
                end
                RUN: begin
                    r_reg   <= stage[2];
                    a_reg   <= a_reg << 1;
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        M         <= stage[2][n-1:0];
                        flag      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    // DONE: result held until the next reset pulse
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modular_multiplier.sv
// Randomized self-checking bench for modular_multiplier at n=8 and n=300,
// compared against plain-arithmetic (A*B) mod p.
module tb_modular_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // n = 8 instance
    logic       rst8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, p8 = 8'd1;
    logic [7:0] m8;
    logic       flag8;

    // n = 300 instance
    logic         rst300 = 1'b0;
    logic [299:0] a300 = '0, b300 = '0, p300 = 300'd1;
    logic [299:0] m300;
    logic         flag300;

    modular_multiplier #(.n(8)) dut8 (
        .clk(clk), .reset(rst8), .A(a8), .B(b8), .p(p8), .M(m8), .flag(flag8)
    );

    modular_multiplier #(.n(300)) dut300 (
        .clk(clk), .reset(rst300), .A(a300), .B(b300), .p(p300), .M(m300), .flag(flag300)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] pp);
        int prod;
        prod = int'(a) * int'(b);
        return 8'(prod % int'(pp));
    endfunction

    function automatic logic [299:0] ref300(input logic [299:0] a, input logic [299:0] b, input logic [299:0] pp);
        logic [599:0] prod;
        logic [599:0] rem;
        prod = {300'd0, a} * {300'd0, b};
        rem  = prod % {300'd0, pp};
        return rem[299:0];
    endfunction

    // One complete n=8 operation; checks reset state, no early flag, latency and result
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] pp, input bit defined);
        logic [7:0] exp;
        exp = ref8(a, b, pp);
        @(negedge clk);
        rst8 = 1'b0; a8 = a; b8 = b; p8 = pp;
        @(negedge clk);
        check({tag, "/reset_state"}, {m8, flag8}, '0);
        rst8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check({tag, "/early"}, {m8, flag8}, '0);
        end
        @(negedge clk);
        check({tag, "/flag"}, flag8, 1'b1);
        if (defined) check({tag, "/M"}, m8, exp);
        $display("n=8 %s A=%0d B=%0d p=%0d M=%0d flag=%0d ref=%0d", tag, a, b, pp, m8, flag8, exp);
    endtask

    task automatic run300(input string tag, input logic [299:0] a, input logic [299:0] b,
                          input logic [299:0] pp);
        logic [299:0] exp;
        exp = ref300(a, b, pp);
        @(negedge clk);
        rst300 = 1'b0; a300 = a; b300 = b; p300 = pp;
        @(negedge clk);
        check({tag, "/reset_state"}, {m300[298:0], flag300}, '0);
        rst300 = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (flag300 !== 1'b0 || m300 !== '0) check({tag, "/early"}, {m300[298:0], flag300}, '0);
        end
        @(negedge clk);
        check({tag, "/flag"}, flag300, 1'b1);
        check({tag, "/M"}, m300, exp);
        a300 = ~a; b300 = ~b;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check({tag, "/hold"}, {m300[298:0], flag300}, {exp[298:0], 1'b1});
        end
        $display("n=300 %s M=%0h flag=%0d ref=%0h", tag, m300, flag300, exp);
    endtask

    function automatic logic [299:0] rand300();
        logic [299:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[267:0], 32'($urandom)};
        return r;
    endfunction

    initial begin
        logic [7:0]   ra, rb, rp;
        logic [299:0] wa, wb, wp;

        // Directed cases with hand-derived results
        run8("d200x100", 8'd200, 8'd100, 8'd251, 1'b1);
        check("d200x100/const", m8, 8'd171);
        run8("d250x250", 8'd250, 8'd250, 8'd251, 1'b1);
        check("d250x250/const", m8, 8'd1);
        run8("d0x123", 8'd0, 8'd123, 8'd251, 1'b1);
        check("d0x123/const", m8, 8'd0);
        run8("d1x77", 8'd1, 8'd77, 8'd251, 1'b1);
        check("d1x77/const", m8, 8'd77);
        run8("p1", 8'd0, 8'd0, 8'd1, 1'b1);
        run8("p255", 8'd254, 8'd254, 8'd255, 1'b1);
        run8("undef", 8'd255, 8'd200, 8'd13, 1'b0);

        // Abort mid-RUN, restart with new operands
        @(negedge clk);
        rst8 = 1'b0; a8 = 8'd200; b8 = 8'd100; p8 = 8'd251;
        @(negedge clk);
        rst8 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("abort/early", {m8, flag8}, '0);
        end
        rst8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
        @(negedge clk);
        check("abort/reset_state", {m8, flag8}, '0);
        rst8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("abort/early2", {m8, flag8}, '0);
        end
        @(negedge clk);
        check("abort/flag", flag8, 1'b1);
        check("abort/M", m8, 8'd15);
        $display("n=8 abort-restart A=3 B=5 p=251 M=%0d flag=%0d ref=15", m8, flag8);

        // Operand change after load must not disturb the result; DONE holds
        @(negedge clk);
        rst8 = 1'b0; a8 = 8'd200; b8 = 8'd100; p8 = 8'd251;
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9;
        for (int k = 3; k <= 8; k++) @(negedge clk);
        check("late_change/early", flag8, 1'b0);
        @(negedge clk);
        check("late_change/flag", flag8, 1'b1);
        check("late_change/M", m8, 8'd171);
        p8 = 8'd17;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("late_change/hold", {m8, flag8}, {8'd171, 1'b1});
        end
        $display("n=8 late-change A:200->7 B:100->9 p=251 M=%0d flag=%0d ref=171", m8, flag8);

        // Randomized n=8 operations
        for (int t = 0; t < 24; t++) begin
            rp = 8'($urandom_range(1, 255));
            ra = 8'($urandom_range(0, int'(rp) - 1));
            rb = 8'($urandom_range(0, int'(rp) - 1));
            run8($sformatf("rnd%0d", t), ra, rb, rp, 1'b1);
        end
        rst8 = 1'b0;

        // Wide reference vector
        run300("wide_vec",
               300'hf3eaf3b95d6d94260bb91af829600303535b2b331893bd3d,
               300'h3731fecb6367c15e7503c0ce01380c628aa5fe01fe31c9f3,
               300'hfffffffffffffffffffffffffffffffeffffffffffffffff);

        // Randomized n=300 operations, including full-width moduli
        for (int t = 0; t < 4; t++) begin
            wp = rand300();
            if (t > 0) wp = wp >> $urandom_range(1, 250);
            if (wp == '0) wp = 300'd1;
            wa = rand300() % wp;
            wb = rand300() % wp;
            run300($sformatf("wide_rnd%0d", t), wa, wb, wp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/modular_multiplier.md
MODULAR_MULTIPLIER -- requirements
Module: modular_multiplier

Interface
REQ-001 The block SHALL have parameter n, default 300, meaning the operand, modulus and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-low reset: 0 sampled at a rising edge clears the block; 1 releases it and starts a multiplication.
REQ-004 The block SHALL have port A, input, n bits, the multiplicand, unsigned, required < p.
REQ-005 The block SHALL have port B, input, n bits, the multiplier, unsigned, required < p.
REQ-006 The block SHALL have port p, input, n bits, the modulus, unsigned, required >= 1.
REQ-007 The block SHALL have port M, output, n bits, registered result (A*B) mod p.
REQ-008 The block SHALL have port flag, output, 1 bit, registered done indicator; 1 means M is valid.

Function
REQ-009 The block SHALL compute M = (A*B) mod p by MSB-first interleaved shift-add: R <- 2R + a_i*B, then reduce R into [0,p), for i = n-1 down to 0.
REQ-010 Each iteration SHALL complete in one clock, reducing via up to two conditional subtractions of p (2R + B < 3p).
REQ-011 Internal accumulator and comparison datapath SHALL be n+2 bits wide so no intermediate overflows for any n-bit p.
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN, DONE.
REQ-013 IDLE: entered on any edge with reset=0; the next edge with reset=1 goes to LOAD.
REQ-014 LOAD: on that first edge with reset=1, the block SHALL capture A, B and p into internal registers, clear R, set iteration counter to n, and enter RUN.
REQ-015 RUN: each edge SHALL perform one iteration using the captured operand bit; after the n-th iteration (same edge) the block SHALL load M with R, set flag=1 and enter DONE.
REQ-016 flag SHALL therefore rise after exactly n+1 rising edges with reset=1 (counting the LOAD edge).
REQ-017 Input changes on A, B, p after the LOAD edge SHALL have no effect on the running computation or the result.
REQ-018 DONE: M and flag SHALL hold constant until reset=0 is sampled; no new operation starts without a reset pulse.
REQ-019 M SHALL read 0 and flag SHALL read 0 at all times before DONE.
REQ-020 If A or B >= p, the result is undefined but the block SHALL still terminate with flag=1 after n+1 edges.

Reset
REQ-021 On any rising edge with reset=0 the block SHALL set M=0, flag=0, R=0, counter=0 and state IDLE, regardless of current state.
REQ-022 A reset sampled mid-RUN SHALL abort the computation; a subsequent release SHALL start a fresh operation from LOAD with current inputs.
REQ-023 Reset SHALL take priority over every other state transition on the same edge.

Verification
REQ-024 n=8, p=251, A=200, B=100, reset held low 1 cycle then high -> flag=1 on the 9th edge after release, M=171; flag=0, M=0 on all prior edges.
REQ-025 n=8, p=251, A=250, B=250 -> M=1; A=0, B=123 -> M=0; A=1, B=77 -> M=77.
REQ-026 n=8, p=251, A=200, B=100, reset driven low at the 4th RUN edge, then high with A=3, B=5 -> flag stays 0 until 9 edges after the second release, then M=15.
REQ-027 n=8, p=251, A=200, B=100 with A, B changed to 7, 9 two edges after release -> M=171 still.
REQ-028 n=300, p=0xfffffffffffffffffffffffffffffffeffffffffffffffff, A=0xf3eaf3b95d6d94260bb91af829600303535b2b331893bd3d, B=0x3731fecb6367c15e7503c0ce01380c628aa5fe01fe31c9f3 -> flag=1 after 301 edges, M equal to the bench arbitrary-precision model value of (A*B) mod p, held stable for 3 further cycles.
